uart_msg_sched: RTL

Round-robin scheduler that shares one UART transmit byte channel among NREQ requesters. Each requester posts a 32-bit register value. The block serialises it as the ASCII line CR 'R' <idx> ':' <8 hex digits> LF and hands the bytes to the UART TX core over a valid/ready handshake. It sits between the register/debug sources and the UART TX core, so the host terminal (and the UART bench model) sees one complete line per request.

---
 rtl/uart_msg_sched_if.sv | 19 +
 rtl/uart_msg_sched.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_msg_sched_if.sv
// Byte channel between the message scheduler and the UART TX core.
// A byte transfers on a clock edge where tx_valid && tx_ready.
interface uart_msg_sched_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_msg_sched.sv
// Round-robin scheduler sharing one UART TX byte channel among NREQ requesters.
// Each granted request is printed as the line: CR 'R' <idx> ':' <8 hex digits> LF.
module uart_msg_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  uart_msg_sched_if.master     tx
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  localparam logic [3:0] LastByte = 4'd12;

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] rr_q;
  logic [31:0]     data_q;
  logic [3:0]      cnt_q;

  logic [IDXW-1:0] win;
  logic            found;
  logic [IDXW-1:0] rr_next;

  // ASCII hex digit, uppercase letters.
  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte k of the line for requester i carrying value d.
  function automatic logic [7:0] line_byte(input logic [3:0] k, input logic [IDXW-1:0] i,
                                           input logic [31:0] d);
    logic [31:0] s;
    // Nibble for k=4 is d[31:28], for k=11 is d[3:0].
    s = d >> (6'd44 - {k, 2'b00});
    case (k)
      4'd0:    return 8'h0D;
      4'd1:    return 8'h52;
      4'd2:    return hex(4'(i));
      4'd3:    return 8'h3A;
      4'd12:   return 8'h0A;
      default: return hex(s[3:0]);
    endcase
  endfunction

  // First active request searching upward from the rr pointer, wrapping.
  always_comb begin
    logic [IDXW-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDXW'((32'(rr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    rr_next = IDXW'((32'(win) + 32'd1) % NREQ);
  end

  // Scheduler FSM with registered outputs; reset abandons any line in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rr_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      tx.tx_valid <= 1'b0;
      tx.tx_byte  <= 8'h00;
    end else begin
      ack <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            idx_q       <= win;
            rr_q        <= rr_next;
            data_q      <= req_data[32*win +: 32];
            cnt_q       <= '0;
            busy        <= 1'b1;
            tx.tx_valid <= 1'b1;
            tx.tx_byte  <= 8'h0D;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (tx.tx_ready) begin
            if (cnt_q == LastByte) begin
              tx.tx_valid <= 1'b0;
              state_q     <= StDone;
            end else begin
              cnt_q      <= cnt_q + 4'd1;
              tx.tx_byte <= line_byte(cnt_q + 4'd1, idx_q, data_q);
            end
          end
        end
        StDone: begin
          ack[idx_q] <= 1'b1;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
